// File: rtl/race_position_tracker.sv
// rtl/race_position_tracker.sv - multi-player position integrator with finish-line saturation
// Single-clock design: an internal tick enable integrates every player's displacement once per TICK_DIV cycles.
module race_position_tracker #(
  parameter int NUM_PLAYERS = 2,
  parameter int DELTA_W     = 5,
  parameter int POS_W       = 32,
  parameter int TICK_DIV    = 1000000,
  parameter int FINISH_POS  = 100000,
  localparam int WIN_W      = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_PLAYERS*DELTA_W-1:0] d_position,
  output logic [NUM_PLAYERS*POS_W-1:0]   position,
  output logic [NUM_PLAYERS-1:0]         finished,
  output logic [WIN_W-1:0]               winner,
  output logic                           winner_valid,
  output logic                           tie,
  output logic                           race_over,
  output logic                           running,
  output logic                           tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W:0]   FIN_WIDE = (POS_W + 1)'(FINISH_POS);
  localparam logic [POS_W-1:0] FIN_POS  = POS_W'(FINISH_POS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                     state;
  logic [CNT_W-1:0]               count;
  logic [NUM_PLAYERS*POS_W-1:0]   pos_next;
  logic [NUM_PLAYERS-1:0]         fin_new;
  logic [WIN_W-1:0]               first_idx;
  logic                           multi_new;
  logic                           all_done;
  logic [POS_W:0]                 sum;

  assign tick      = (state == S_RUN) && (count == CNT_LAST);
  assign race_over = (state == S_DONE);
  assign running   = (state == S_RUN);

  // One extra bit of headroom keeps the sum from wrapping before the saturation compare.
  always_comb begin
    pos_next = position;
    fin_new  = '0;
    sum      = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      sum = {1'b0, position[i*POS_W +: POS_W]} + (POS_W + 1)'(d_position[i*DELTA_W +: DELTA_W]);
      if (!finished[i]) begin
        if (sum >= FIN_WIDE) begin
          pos_next[i*POS_W +: POS_W] = FIN_POS;
          fin_new[i]                 = 1'b1;
        end else begin
          pos_next[i*POS_W +: POS_W] = sum[POS_W-1:0];
        end
      end
    end
  end

  // Descending scan leaves the lowest newly-finishing index as the winner candidate.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (fin_new[i]) begin
        first_idx = WIN_W'(i);
      end
    end
  end

  assign multi_new = ((fin_new & (fin_new - NUM_PLAYERS'(1))) != '0);
  assign all_done  = &(finished | fin_new);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      position     <= '0;
      finished     <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      tie          <= 1'b0;
    end else if (start) begin
      state        <= S_RUN;
      count        <= '0;
      position     <= '0;
      finished     <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      tie          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          count <= '0;
        end
        S_RUN: begin
          if (abort) begin
            state <= S_DONE;
          end else begin
            count <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
            if (tick) begin
              position <= pos_next;
              finished <= finished | fin_new;
              if (!winner_valid && (fin_new != '0)) begin
                winner       <= first_idx;
                winner_valid <= 1'b1;
                tie          <= multi_new;
              end
              if (all_done) begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_position_tracker.sv
// tb/tb_race_position_tracker.sv - self-checking bench for race_position_tracker
// Vector table, hand-written corner sequences and randomized cycles against a behavioural race model.
module tb_race_position_tracker;

  localparam int NP   = 2;
  localparam int DW   = 5;
  localparam int PW   = 32;
  localparam int TDIV = 4;
  localparam int FIN  = 20;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [NP*DW-1:0]  d_position;
  logic [NP*PW-1:0]  position;
  logic [NP-1:0]     finished;
  logic [0:0]        winner;
  logic              winner_valid;
  logic              tie;
  logic              race_over;
  logic              running;
  logic              tick;

  int total;
  int bad;

  // Behavioural model of the race
  int m_pos[NP];
  bit m_fin[NP];
  int m_win;
  bit m_wv;
  bit m_tie;
  bit m_run;
  bit m_over;
  int m_phase;

  typedef struct {
    int d0;
    int d1;
    int ticks;
    int p0;
    int p1;
    int fin;
    int win;
    int wv;
    int tie;
    int over;
    int run;
  } vec_t;

  vec_t vecs[6];

  race_position_tracker #(
    .NUM_PLAYERS(NP),
    .DELTA_W(DW),
    .POS_W(PW),
    .TICK_DIV(TDIV),
    .FINISH_POS(FIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .d_position(d_position),
    .position(position),
    .finished(finished),
    .winner(winner),
    .winner_valid(winner_valid),
    .tie(tie),
    .race_over(race_over),
    .running(running),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_pos[i] = 0;
      m_fin[i] = 1'b0;
    end
    m_win = 0; m_wv = 0; m_tie = 0; m_run = 0; m_over = 0; m_phase = 0;
  endtask

  function automatic bit model_tick();
    return m_run && (m_phase == TDIV - 1);
  endfunction

  task automatic model_integrate(input int d0, input int d1);
    int d[NP];
    int first;
    int newc;
    bit all;
    d[0] = d0; d[1] = d1;
    first = -1; newc = 0;
    for (int i = 0; i < NP; i++) begin
      if (!m_fin[i]) begin
        if (m_pos[i] + d[i] >= FIN) begin
          m_pos[i] = FIN;
          m_fin[i] = 1'b1;
          newc++;
          if (first < 0) first = i;
        end else begin
          m_pos[i] = m_pos[i] + d[i];
        end
      end
    end
    if (newc > 0 && !m_wv) begin
      m_win = first; m_wv = 1; m_tie = (newc > 1);
    end
    all = 1;
    for (int i = 0; i < NP; i++) all = all & m_fin[i];
    if (all) begin
      m_run = 0; m_over = 1;
    end
  endtask

  task automatic model_edge(input bit s, input bit a, input int d0, input int d1);
    if (s) begin
      model_reset();
      m_run = 1;
    end else if (m_run) begin
      if (a) begin
        m_run = 0; m_over = 1;
      end else begin
        bit t;
        t = model_tick();
        m_phase = (m_phase + 1) % TDIV;
        if (t) model_integrate(d0, d1);
      end
    end
  endtask

  task automatic check_outputs();
    chk("pos0", position[PW-1:0], m_pos[0]);
    chk("pos1", position[2*PW-1:PW], m_pos[1]);
    chk("finished", finished, {m_fin[1], m_fin[0]});
    chk("winner", winner, m_win);
    chk("winner_valid", winner_valid, m_wv);
    chk("tie", tie, m_tie);
    chk("race_over", race_over, m_over);
    chk("running", running, m_run);
  endtask

  // Called one time unit after a rising edge; drives inputs, checks tick, then the registered results.
  task automatic cycle(input bit s, input bit a, input int d0, input int d1);
    start = s;
    abort = a;
    d_position = {DW'(d1), DW'(d0)};
    chk("tick", tick, model_tick());
    @(posedge clk);
    model_edge(s, a, d0, d1);
    #1;
    check_outputs();
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    d_position = '0;
    model_reset();

    vecs[0] = '{5, 3, 4, 20, 12, 1, 0, 1, 0, 0, 1};
    vecs[1] = '{5, 3, 7, 20, 20, 3, 0, 1, 0, 1, 0};
    vecs[2] = '{10, 10, 2, 20, 20, 3, 0, 1, 1, 1, 0};
    vecs[3] = '{31, 0, 3, 20, 0, 1, 0, 1, 0, 0, 1};
    vecs[4] = '{3, 7, 3, 9, 20, 2, 1, 1, 0, 0, 1};
    vecs[5] = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1};

    @(posedge clk);
    #1;
    chk("reset_pos", position, 0);
    chk("reset_flags", {finished, winner, winner_valid, tie, race_over, running, tick}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    cycle(0, 1, 0, 0);
    chk("idle_abort_over", race_over, 0);

    for (int v = 0; v < 6; v++) begin
      cycle(1, 0, vecs[v].d0, vecs[v].d1);
      for (int c = 0; c < vecs[v].ticks * TDIV; c++) cycle(0, 0, vecs[v].d0, vecs[v].d1);
      chk("vec_p0", position[PW-1:0], vecs[v].p0);
      chk("vec_p1", position[2*PW-1:PW], vecs[v].p1);
      chk("vec_fin", finished, vecs[v].fin);
      chk("vec_win", winner, vecs[v].win);
      chk("vec_wv", winner_valid, vecs[v].wv);
      chk("vec_tie", tie, vecs[v].tie);
      chk("vec_over", race_over, vecs[v].over);
      chk("vec_run", running, vecs[v].run);
    end

    // Abort mid-race freezes positions
    cycle(1, 0, 5, 0);
    for (int c = 0; c < 2 * TDIV; c++) cycle(0, 0, 5, 0);
    chk("abort_pre_p0", position[PW-1:0], 10);
    cycle(0, 1, 5, 0);
    for (int c = 0; c < 2 * TDIV; c++) begin
      cycle(0, 0, 5, 0);
      chk("abort_tick", tick, 0);
    end
    chk("abort_p0", position[PW-1:0], 10);
    chk("abort_over", race_over, 1);

    // Restart while running
    cycle(1, 0, 5, 1);
    for (int c = 0; c < 3 * TDIV; c++) cycle(0, 0, 5, 1);
    chk("restart_pre_p0", position[PW-1:0], 15);
    cycle(1, 0, 5, 1);
    chk("restart_p0", position[PW-1:0], 0);
    chk("restart_fin", finished, 0);
    for (int c = 0; c < TDIV - 1; c++) cycle(0, 0, 5, 1);
    chk("restart_hold_p0", position[PW-1:0], 0);
    cycle(0, 0, 5, 1);
    chk("restart_first_p0", position[PW-1:0], 5);

    // Asynchronous reset between clock edges
    for (int c = 0; c < 6; c++) cycle(0, 0, 5, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_pos", position, 0);
    chk("async_flags", {finished, winner_valid, running, tick}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) cycle(0, 0, 5, 1);
    chk("async_stay_idle", running, 0);

    // Randomized cycles against the model
    for (int c = 0; c < 3000; c++) begin
      bit s;
      bit a;
      int d0;
      int d1;
      s = ($urandom_range(0, 49) == 0);
      a = ($urandom_range(0, 79) == 0);
      d0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      d1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      cycle(s, a, d0, d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
